// File: rtl/param_cache.sv
// Write-through set-associative cache with round-robin replacement and a
// pipelined line fill; memory replies to reads in request order.
module param_cache #(
    parameter int O      = 4,
    parameter int S      = 5,
    parameter int W      = 2,
    parameter int WALLOC = 1,
    parameter int CW     = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mem_ready,
    output logic [31:0]   o_mem_addr,
    output logic          o_mem_ren,
    output logic          o_mem_wen,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    input  logic          i_mem_valid,
    output logic          o_busy,
    input  logic [31:0]   i_req_addr,
    input  logic          i_req_ren,
    input  logic          i_req_wen,
    input  logic [3:0]    i_req_mask,
    input  logic [31:0]   i_req_wdata,
    output logic [31:0]   o_res_rdata,
    output logic [CW-1:0] o_hit_count,
    output logic [CW-1:0] o_miss_count
);
    localparam int D    = 1 << (O - 2);
    localparam int SETS = 1 << S;
    localparam int TW   = 32 - O - S;
    localparam int WB   = (W > 1) ? $clog2(W) : 1;
    localparam int IW   = S + O - 2;
    localparam int CNTW = O - 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    state_t state_reg, state_next;

    logic [31:0]   addr_reg, wdata_reg, res_reg;
    logic [3:0]    mask_reg;
    logic          write_reg, hit_pend_reg, rst_d_reg;
    logic [WB-1:0] way_reg;
    logic [CNTW-1:0] req_cnt_reg, resp_cnt_reg;
    logic [CW-1:0] hit_cnt_reg, miss_cnt_reg;
    logic [WB-1:0] rr_reg [SETS];

    // Lookup follows the live request in IDLE and the latched one afterwards.
    logic          in_idle;
    logic [TW-1:0] lk_tag;
    logic [S-1:0]  lk_set;
    logic [IW-1:0] lk_idx;
    logic [3:0]    lk_mask;
    logic [31:0]   lk_wdata;
    assign in_idle  = (state_reg == IDLE);
    assign lk_tag   = in_idle ? i_req_addr[31:O+S]  : addr_reg[31:O+S];
    assign lk_set   = in_idle ? i_req_addr[O+S-1:O] : addr_reg[O+S-1:O];
    assign lk_idx   = in_idle ? i_req_addr[O+S-1:2] : addr_reg[O+S-1:2];
    assign lk_mask  = in_idle ? i_req_mask  : mask_reg;
    assign lk_wdata = in_idle ? i_req_wdata : wdata_reg;

    logic [W-1:0]  way_hit, way_free;
    logic [31:0]   way_word [W];
    logic          wr_en, fill_clr, fill_last, latch, cnt_hit, cnt_miss;
    logic [WB-1:0] wr_way, hit_way, victim;
    logic [IW-1:0] wr_idx;
    logic [31:0]   wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_way
            logic [31:0]   data_mem [D*SETS];
            logic [TW-1:0] tag_mem [SETS];
            logic [SETS-1:0] valid_reg;

            always_ff @(posedge i_clk) begin
                if (wr_en && wr_way == WB'(gi))
                    data_mem[wr_idx] <= wr_data;
                if (fill_last && way_reg == WB'(gi))
                    tag_mem[lk_set] <= lk_tag;
            end

            // Valid drops on the first fill beat so a half-filled line never hits.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    valid_reg <= '0;
                end else if (way_reg == WB'(gi)) begin
                    if (fill_clr)
                        valid_reg[lk_set] <= 1'b0;
                    if (fill_last)
                        valid_reg[lk_set] <= 1'b1;
                end
            end

            assign way_word[gi] = data_mem[lk_idx];
            assign way_hit[gi]  = valid_reg[lk_set] && (tag_mem[lk_set] == lk_tag);
            assign way_free[gi] = !valid_reg[lk_set];
        end
    endgenerate

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    logic        hit;
    logic [31:0] hit_word, lk_me, merged, word_off;
    always_comb begin
        hit_way = '0;
        victim  = rr_reg[lk_set];
        for (int i = W - 1; i >= 0; i--) begin
            if (way_hit[i])
                hit_way = WB'(i);
            if (way_free[i])
                victim = WB'(i);
        end
    end
    assign hit      = |way_hit;
    assign hit_word = way_word[hit_way];
    assign lk_me    = expand(lk_mask);
    assign merged   = (lk_wdata & lk_me) | ((hit ? hit_word : 32'h0) & ~lk_me);
    assign word_off = 32'(addr_reg[O-1:0]) >> 2;

    always_comb begin
        state_next  = state_reg;
        o_busy      = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        o_res_rdata = 32'h0;
        wr_en       = 1'b0;
        wr_way      = hit_way;
        wr_idx      = lk_idx;
        wr_data     = merged;
        fill_clr    = 1'b0;
        fill_last   = 1'b0;
        latch       = 1'b0;
        cnt_hit     = 1'b0;
        cnt_miss    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rst_d_reg && (i_req_ren || i_req_wen)) begin
                    if (hit && i_req_ren) begin
                        o_res_rdata = hit_word & lk_me;
                        cnt_hit     = 1'b1;
                    end else if (hit && i_mem_ready) begin
                        o_mem_wen   = 1'b1;
                        o_mem_addr  = i_req_addr;
                        o_mem_wdata = merged;
                        wr_en       = 1'b1;
                        cnt_hit     = 1'b1;
                    end else begin
                        o_busy   = 1'b1;
                        latch    = 1'b1;
                        cnt_miss = !hit;
                        if (hit || (i_req_wen && WALLOC == 0))
                            state_next = WRITE;
                        else
                            state_next = FILL;
                    end
                end
            end
            FILL: begin
                o_busy     = 1'b1;
                o_mem_ren  = (req_cnt_reg != CNTW'(D));
                o_mem_addr = {addr_reg[31:O], {O{1'b0}}} + (32'(req_cnt_reg) << 2);
                if (i_mem_valid) begin
                    wr_en    = 1'b1;
                    wr_way   = way_reg;
                    wr_idx   = IW'((32'(lk_set) << (O - 2)) + 32'(resp_cnt_reg));
                    wr_data  = i_mem_rdata;
                    fill_clr = (resp_cnt_reg == '0);
                    if (resp_cnt_reg == CNTW'(D - 1)) begin
                        fill_last  = 1'b1;
                        state_next = write_reg ? WRITE : DONE;
                    end
                end
            end
            WRITE: begin
                o_busy = 1'b1;
                if (i_mem_ready) begin
                    o_mem_wen   = 1'b1;
                    o_mem_addr  = addr_reg;
                    o_mem_wdata = merged;
                    wr_en       = hit;
                    cnt_hit     = hit_pend_reg;
                    state_next  = DONE;
                end
            end
            DONE: begin
                o_res_rdata = write_reg ? 32'h0 : res_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (i_rst || rst_d_reg) begin
            o_busy      = 1'b0;
            o_mem_ren   = 1'b0;
            o_mem_wen   = 1'b0;
            o_mem_addr  = 32'h0;
            o_mem_wdata = 32'h0;
            o_res_rdata = 32'h0;
            wr_en       = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        rst_d_reg <= i_rst;
        if (i_rst) begin
            state_reg    <= IDLE;
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            req_cnt_reg  <= '0;
            resp_cnt_reg <= '0;
            res_reg      <= 32'h0;
            hit_pend_reg <= 1'b0;
            write_reg    <= 1'b0;
            way_reg      <= '0;
            for (int s = 0; s < SETS; s++)
                rr_reg[s] <= '0;
        end else begin
            state_reg <= state_next;
            if (latch) begin
                addr_reg     <= i_req_addr;
                mask_reg     <= i_req_mask;
                wdata_reg    <= i_req_wdata;
                write_reg    <= i_req_wen && !i_req_ren;
                way_reg      <= hit ? hit_way : victim;
                hit_pend_reg <= hit;
                req_cnt_reg  <= '0;
                resp_cnt_reg <= '0;
                res_reg      <= 32'h0;
            end
            if (state_reg == FILL) begin
                if (o_mem_ren && i_mem_ready)
                    req_cnt_reg <= req_cnt_reg + 1'b1;
                if (i_mem_valid) begin
                    resp_cnt_reg <= resp_cnt_reg + 1'b1;
                    if (32'(resp_cnt_reg) == word_off)
                        res_reg <= i_mem_rdata & expand(mask_reg);
                end
            end
            if (fill_last)
                rr_reg[lk_set] <= (W == 1) ? '0 : rr_reg[lk_set] + WB'(1);
            if (cnt_hit && hit_cnt_reg != '1)
                hit_cnt_reg <= hit_cnt_reg + 1'b1;
            if (cnt_miss && miss_cnt_reg != '1)
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
    end

    assign o_hit_count  = hit_cnt_reg;
    assign o_miss_count = miss_cnt_reg;

endmodule

// File: tb/tb_param_cache.sv
// Bench for param_cache: instance 0 write-allocate, instance 1 write-no-allocate,
// each behind a one-cycle-latency memory model.
module tb_param_cache;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_ready [2], mem_ren [2], mem_wen [2], mem_valid [2];
    logic        busy [2], req_ren [2], req_wen [2];
    logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic [31:0] req_addr [2], req_wdata [2], res_rdata [2];
    logic [3:0]  req_mask [2];
    logic [15:0] hit_cnt [2], miss_cnt [2];

    int errors = 0;
    int checks = 0;
    int exp_hits [2];
    int exp_misses [2];
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [2][1024];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            param_cache #(.O(4), .S(5), .W(2), .WALLOC(gi == 0 ? 1 : 0), .CW(16)) u_dut (
                .i_clk        (clk),
                .i_rst        (rst),
                .i_mem_ready  (mem_ready[gi]),
                .o_mem_addr   (mem_addr[gi]),
                .o_mem_ren    (mem_ren[gi]),
                .o_mem_wen    (mem_wen[gi]),
                .o_mem_wdata  (mem_wdata[gi]),
                .i_mem_rdata  (mem_rdata[gi]),
                .i_mem_valid  (mem_valid[gi]),
                .o_busy       (busy[gi]),
                .i_req_addr   (req_addr[gi]),
                .i_req_ren    (req_ren[gi]),
                .i_req_wen    (req_wen[gi]),
                .i_req_mask   (req_mask[gi]),
                .i_req_wdata  (req_wdata[gi]),
                .o_res_rdata  (res_rdata[gi]),
                .o_hit_count  (hit_cnt[gi]),
                .o_miss_count (miss_cnt[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a << 16) ^ a ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    // Memory model: answers each accepted read one cycle later.
    int          ren_cnt [2];
    int          wen_cnt [2];
    int          excl_err = 0;
    logic [31:0] last_wen_addr [2], last_wen_data [2];
    logic [31:0] ren_hist [2][64];
    logic [31:0] store [2][1024];
    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 1024; i++)
                store[u][i] = pat(32'(i) << 2);
            mem_valid[u] = 1'b0;
            mem_rdata[u] = 32'h0;
            ren_cnt[u]   = 0;
            wen_cnt[u]   = 0;
        end
        forever begin
            @(posedge clk);
            for (int u = 0; u < 2; u++) begin
                if (mem_ren[u] && mem_wen[u])
                    excl_err++;
                mem_valid[u] <= mem_ren[u] && mem_ready[u];
                mem_rdata[u] <= store[u][mem_addr[u][11:2]];
                if (mem_ren[u] && mem_ready[u]) begin
                    ren_hist[u][ren_cnt[u] % 64] = mem_addr[u];
                    ren_cnt[u]++;
                end
                if (mem_wen[u] && mem_ready[u]) begin
                    store[u][mem_addr[u][11:2]] = mem_wdata[u];
                    last_wen_addr[u] = mem_addr[u];
                    last_wen_data[u] = mem_wdata[u];
                    wen_cnt[u]++;
                end
            end
        end
    end

    task automatic cpu_op(input int u, input bit wr, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wdata,
                          input bit exp_hit, input int exp_ren, input int exp_lat,
                          input string name);
        logic [31:0] me, merged, got;
        int ren0, wen0, cyc;
        bit done;
        @(posedge clk);
        #1;
        me     = expand(mask);
        ren0   = ren_cnt[u];
        wen0   = wen_cnt[u];
        merged = (wdata & me) | (ref_mem[u][addr[11:2]] & ~me);
        exp_q.push_back(wr ? 32'h0 : (ref_mem[u][addr[11:2]] & me));
        if (wr)
            ref_mem[u][addr[11:2]] = merged;
        if (exp_hit) exp_hits[u]++;
        else         exp_misses[u]++;
        req_addr[u]  = addr;
        req_mask[u]  = mask;
        req_wdata[u] = wdata;
        req_ren[u]   = !wr;
        req_wen[u]   = wr;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!busy[u])
                done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: busy still 1 after %0d cycles", name, cyc);
        end
        got = exp_q.pop_front();
        checks++;
        if (res_rdata[u] !== got) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", name, res_rdata[u], got);
        end
        if (exp_lat > 0) begin
            checks++;
            if (cyc !== exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
            end
        end
        @(posedge clk);
        #1;
        req_ren[u] = 1'b0;
        req_wen[u] = 1'b0;
        @(negedge clk);
        checks += 4;
        if (hit_cnt[u] !== 16'(exp_hits[u])) begin
            errors++;
            $display("FAIL %s hit_count: got %0d expected %0d", name, hit_cnt[u], exp_hits[u]);
        end
        if (miss_cnt[u] !== 16'(exp_misses[u])) begin
            errors++;
            $display("FAIL %s miss_count: got %0d expected %0d", name, miss_cnt[u], exp_misses[u]);
        end
        if (ren_cnt[u] - ren0 !== exp_ren) begin
            errors++;
            $display("FAIL %s ren_beats: got %0d expected %0d", name, ren_cnt[u] - ren0, exp_ren);
        end
        if (wen_cnt[u] - wen0 !== (wr ? 1 : 0)) begin
            errors++;
            $display("FAIL %s wen_beats: got %0d expected %0d", name, wen_cnt[u] - wen0, wr ? 1 : 0);
        end
        if (wr) begin
            checks += 2;
            if (last_wen_data[u] !== merged) begin
                errors++;
                $display("FAIL %s wen_data: got %h expected %h", name, last_wen_data[u], merged);
            end
            if (last_wen_addr[u] !== addr) begin
                errors++;
                $display("FAIL %s wen_addr: got %h expected %h", name, last_wen_addr[u], addr);
            end
        end
        if (exp_ren == D) begin
            for (int k = 0; k < D; k++) begin
                checks++;
                if (ren_hist[u][(ren0 + k) % 64] !== ({addr[31:4], 4'h0} + 32'(4 * k))) begin
                    errors++;
                    $display("FAIL %s ren_addr[%0d]: got %h expected %h", name, k,
                             ren_hist[u][(ren0 + k) % 64], {addr[31:4], 4'h0} + 32'(4 * k));
                end
            end
        end
        $display("op %-20s u=%0d addr=%h rdata=%h cycles=%0d", name, u, addr, res_rdata[u], cyc);
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (busy[0] !== 1'b0 || mem_ren[0] !== 1'b0 || mem_wen[0] !== 1'b0 || res_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL %s outputs: busy=%b ren=%b wen=%b rdata=%h expected all 0",
                     name, busy[0], mem_ren[0], mem_wen[0], res_rdata[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_addr[0] = 32'h104;
        req_mask[0] = 4'hF;
        req_ren[0]  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
        @(posedge clk);
        #1;
        req_ren[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (hit_cnt[0] !== 16'd0 || miss_cnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got hit=%0d miss=%0d expected 0/0", hit_cnt[0], miss_cnt[0]);
        end
        $display("op reset done");
    endtask

    task automatic test_read_miss_hit();
        cpu_op(0, 0, 32'h104, 4'hF, 32'h0, 0, D, 7, "read_miss");
        cpu_op(0, 0, 32'h104, 4'hF, 32'h0, 1, 0, 1, "read_hit");
        cpu_op(0, 0, 32'h10C, 4'b0101, 32'h0, 1, 0, 1, "read_hit_masked");
    endtask

    task automatic test_write_hit();
        cpu_op(0, 1, 32'h104, 4'b0010, 32'h0000_AB00, 1, 0, 1, "write_hit");
        cpu_op(0, 0, 32'h104, 4'hF, 32'h0, 1, 0, 1, "read_merged");
    endtask

    task automatic test_write_stall();
        mem_ready[0] = 1'b0;
        fork
            cpu_op(0, 1, 32'h108, 4'b1001, 32'hDEAD_BEEF, 1, 0, 0, "write_stall");
            begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (busy[0] !== 1'b1 || mem_wen[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_busy: got busy=%b wen=%b expected busy=1 wen=0", busy[0], mem_wen[0]);
                end
                repeat (2) @(negedge clk);
                mem_ready[0] = 1'b1;
            end
        join
        cpu_op(0, 0, 32'h108, 4'hF, 32'h0, 1, 0, 1, "read_after_stall");
    endtask

    task automatic test_write_miss_alloc();
        cpu_op(0, 1, 32'h30C, 4'b1100, 32'h1234_5678, 0, D, 8, "wmiss_alloc");
        cpu_op(0, 0, 32'h30C, 4'hF, 32'h0, 1, 0, 1, "read_alloc_line");
    endtask

    task automatic test_evict();
        cpu_op(0, 0, 32'h000, 4'hF, 32'h0, 0, D, 7, "fill_set0_a");
        cpu_op(0, 0, 32'h200, 4'hF, 32'h0, 0, D, 7, "fill_set0_b");
        cpu_op(0, 0, 32'h400, 4'hF, 32'h0, 0, D, 7, "fill_set0_c");
        cpu_op(0, 0, 32'h000, 4'hF, 32'h0, 0, D, 7, "evicted_reread");
        cpu_op(0, 0, 32'h404, 4'hF, 32'h0, 1, 0, 1, "survivor_hit");
    endtask

    task automatic test_no_alloc();
        cpu_op(1, 1, 32'h800, 4'hF, 32'hA1B2_C3D4, 0, 0, 3, "wmiss_noalloc");
        cpu_op(1, 0, 32'h800, 4'hF, 32'h0, 0, D, 7, "read_after_noalloc");
    endtask

    task automatic test_reset_midfill();
        int beat, cyc;
        @(posedge clk);
        #1;
        req_addr[0] = 32'h504;
        req_mask[0] = 4'hF;
        req_ren[0]  = 1'b1;
        beat = 0;
        cyc  = 0;
        while (!(mem_valid[0] && beat == 2) && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (mem_valid[0] && beat < 2 && busy[0])
                beat++;
            else if (mem_valid[0] && beat == 2)
                break;
        end
        checks++;
        if (!(mem_valid[0] && beat == 2)) begin
            errors++;
            $display("FAIL midfill_reach: got beat %0d expected third beat in flight", beat);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_ren[0] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            exp_hits[u]   = 0;
            exp_misses[u] = 0;
        end
        repeat (2) @(posedge clk);
        $display("op midfill reset applied");
        cpu_op(0, 0, 32'h504, 4'hF, 32'h0, 0, D, 7, "reread_after_rst");
        cpu_op(0, 0, 32'h104, 4'hF, 32'h0, 0, D, 7, "old_line_gone");
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 1024; i++)
                ref_mem[u][i] = pat(32'(i) << 2);
            mem_ready[u]  = 1'b1;
            req_addr[u]   = 32'h0;
            req_wdata[u]  = 32'h0;
            req_mask[u]   = 4'h0;
            req_ren[u]    = 1'b0;
            req_wen[u]    = 1'b0;
            exp_hits[u]   = 0;
            exp_misses[u] = 0;
        end
        rst = 1'b1;
        test_reset();
        test_read_miss_hit();
        test_write_hit();
        test_write_stall();
        test_write_miss_alloc();
        test_evict();
        test_no_alloc();
        test_reset_midfill();
        checks++;
        if (excl_err !== 0) begin
            errors++;
            $display("FAIL ren_wen_exclusive: got %0d overlapping cycles expected 0", excl_err);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_cache.md
PARAM_CACHE -- requirements
Module: param_cache

Interface
REQ-001 SHALL provide parameter O, default 4, meaning log2 bytes per line (O>=2; D=2^(O-2) words per line).
REQ-002 SHALL provide parameter S, default 5, meaning log2 number of sets (S>=1).
REQ-003 SHALL provide parameter W, default 2, meaning associativity: 1, 2, 4 or 8 ways.
REQ-004 SHALL provide parameter WALLOC, default 1, meaning write-miss policy: 1 = write-allocate, 0 = write-no-allocate.
REQ-005 SHALL provide parameter CW, default 16, meaning width of the hit and miss counters.
REQ-006 SHALL have one clock and a synchronous active-high reset: i_clk input 1 (clock, all state on rising edge); i_rst input 1 (synchronous, active-high).
REQ-007 SHALL have memory-side ports: i_mem_ready in 1 (memory accepts request this cycle); o_mem_addr out 32 (word-aligned address); o_mem_ren out 1; o_mem_wen out 1; o_mem_wdata out 32; i_mem_rdata in 32; i_mem_valid in 1 (read data returned, in request order).
REQ-008 SHALL have CPU-side ports: o_busy out 1; i_req_addr in 32 (word-aligned); i_req_ren in 1; i_req_wen in 1; i_req_mask in 4 (byte enables); i_req_wdata in 32; o_res_rdata out 32.
REQ-009 SHALL have statistics outputs: o_hit_count out CW; o_miss_count out CW.

Function
REQ-010 SHALL decode the address as tag [31:O+S], set [O+S-1:O] and word [O-1:2]; a way hits when it is valid and its tag matches.
REQ-011 SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-012 In IDLE, a read hit SHALL drive o_res_rdata combinationally with the hit word, with bytes outside i_req_mask forced to zero; o_busy stays 0.
REQ-013 In IDLE, a write hit with i_mem_ready=1 SHALL assert o_mem_wen combinationally with the merged word (mask bytes from i_req_wdata, other bytes from the cache) and update the hit way at the next edge; o_busy stays 0.
REQ-014 In IDLE, a write hit with i_mem_ready=0, or any miss, SHALL assert o_busy combinationally in that cycle.
REQ-015 On entry to a miss or stalled write, the block SHALL latch address, mask, wdata, operation and victim way.
REQ-016 On a read miss, or a write miss with WALLOC=1, the next state SHALL be FILL; on a write miss with WALLOC=0, or a write hit stalled on i_mem_ready, the next state SHALL be WRITE.
REQ-017 Victim selection: the lowest-index invalid way; if all ways are valid, the way indicated by that set's round-robin pointer, which increments mod W on every completed fill into the set.
REQ-018 In FILL, the block SHALL issue o_mem_ren for line words 0..D-1 at base address {tag,set,O'b0}, one word per cycle while i_mem_ready=1, holding the address when i_mem_ready=0; requests may be outstanding back-to-back.
REQ-019 Each i_mem_valid response SHALL be written into the victim way at the next word index.
REQ-020 On the D-th response, the block SHALL set the victim's tag and valid bit, then go to DONE for a read or to WRITE for a write.
REQ-021 The victim's valid bit SHALL be cleared at the first fill response, so a partially filled line never hits.
REQ-022 In WRITE, the block SHALL drive o_mem_wen, the latched address and the merged word while i_mem_ready=1; in that cycle it SHALL update the cache word only if the line is resident, then go to DONE.
REQ-023 In DONE, o_busy SHALL be 0 for exactly one cycle, o_res_rdata SHALL carry the latched masked read word (0 for writes), and the next state SHALL be IDLE.
REQ-024 o_busy SHALL be 1 throughout FILL and WRITE.
REQ-025 o_mem_ren and o_mem_wen SHALL never both be 1.
REQ-026 Request inputs are ignored outside IDLE; the CPU holds them stable while o_busy=1.
REQ-027 i_mem_valid received in IDLE, WRITE or DONE SHALL be ignored.
REQ-028 o_hit_count SHALL increment once per IDLE request that hits (counted on completion); o_miss_count SHALL increment once per IDLE miss; both saturate at 2^CW-1.
REQ-029 Simultaneous i_req_ren and i_req_wen is illegal; the behaviour is don't-care.

Reset
REQ-030 When i_rst=1 at a clock edge: state=IDLE, all valid bits=0, round-robin pointers=0, both counters=0, and outstanding fill responses are discarded.
REQ-031 While in reset and in the cycle after it: o_busy=0, o_mem_ren=0, o_mem_wen=0, o_res_rdata=0.
REQ-032 Reset asserted mid-FILL or mid-WRITE SHALL abort the operation with no line left valid.

Verification
REQ-033 With defaults, after reset, read 0x0000_0104 mask 1111 with 1-cycle memory latency -> o_busy=1, ren to 0x100/104/108/10C, DONE returns word at 0x104, o_miss_count=1.
REQ-034 Repeat the same read -> same-cycle data, o_busy=0, no memory traffic, o_hit_count=1.
REQ-035 Write hit at 0x104, mask 0010, wdata 0x0000AB00 -> o_mem_wen same cycle with byte 1 replaced; subsequent read returns the merged word.
REQ-036 With W=2, fill three lines mapping to set 0 (0x000, 0x200, 0x400) -> the third line evicts way 0; a read of 0x000 then misses.
REQ-037 With WALLOC=0, write miss at 0x800 -> one o_mem_wen, no o_mem_ren, and a later read of 0x800 misses.
REQ-038 Assert i_rst during the third fill beat, then re-read the same address -> miss with a full 4-word refill.
